// File: rtl/ro_meas_pkg.sv
// Shared types and defaults for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_GATE,
    ST_STOP,
    ST_RESULT
  } ro_meas_state_e;

  localparam int SETTLE_DEF = 4;
  localparam int WARM_DEF   = 8;
  localparam int TRIM_W     = 5;

  // Width of a down-counter able to hold the larger of two preload values.
  function automatic int tmr_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/ro_meas_ctrl_edge_sync.sv
// Brings the divided oscillator output into wb_clk_i and flags rising edges.
module ro_edge_sync (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic din,
  output logic rise
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: settle, warm up, gate-count, report.
// Optional feature: define RO_AUTOSCAN_EN to add scan_en and sweep all mux inputs.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SETUP  | select/trim applied, oscillator held off for SETTLE cycles
// ENABLE | oscillator running for WARM cycles, edges ignored
// GATE   | counting synchronised rising edges for gate cycles
// STOP   | oscillator off for one cycle
// RESULT | result offered until res_ready
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter  int N_RO   = 16,
  parameter  int CNT_W  = 24,
  parameter  int GATE_W = 16,
  parameter  int SETTLE = SETTLE_DEF,
  parameter  int WARM   = WARM_DEF,
  localparam int SEL_W  = $clog2(N_RO)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
`ifdef RO_AUTOSCAN_EN
  input  logic              scan_en,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [TRIM_W-1:0] cmd_trim,
  input  logic [GATE_W-1:0] cmd_gate,
  input  logic              abort,
  input  logic              ro_in,
  output logic              ro_start,
  output logic [TRIM_W-1:0] ro_trim,
  output logic [SEL_W-1:0]  mux_sel,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [SEL_W-1:0]  res_sel,
  output logic              res_ovf,
  output logic              busy
);

  localparam int TMR_W = tmr_width(SETTLE, WARM);

  ro_meas_state_e state_q, state_d;

  logic [SEL_W-1:0]  sel_q;
  logic [TRIM_W-1:0] trim_q;
  logic [GATE_W-1:0] gate_q, gcnt_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              init_q;
  logic              rise;
  logic              accept;
  logic              scan_more;

  ro_edge_sync u_edge_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .din      (ro_in),
    .rise     (rise)
  );

  assign cmd_ready = init_q && (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign ro_start  = (state_q == ST_ENABLE) || (state_q == ST_GATE);
  assign res_valid = (state_q == ST_RESULT);
  assign busy      = (state_q != ST_IDLE);
  assign mux_sel   = sel_q;
  assign ro_trim   = trim_q;
  assign res_sel   = sel_q;
  assign res_count = cnt_q;
  assign res_ovf   = ovf_q;

`ifdef RO_AUTOSCAN_EN
  logic scan_q;
  assign scan_more = scan_q && (sel_q != SEL_W'(N_RO - 1));
`else
  assign scan_more = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  if (tmr_q == '0) state_d = ST_ENABLE;
      ST_ENABLE: if (tmr_q == '0) state_d = (gate_q == '0) ? ST_STOP : ST_GATE;
      ST_GATE:   if (gcnt_q == GATE_W'(1)) state_d = ST_STOP;
      ST_STOP:   state_d = ST_RESULT;
      ST_RESULT: if (res_ready) state_d = scan_more ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sel_q  <= '0;
      trim_q <= '0;
      gate_q <= '0;
      gcnt_q <= '0;
      tmr_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      init_q <= 1'b0;
`ifdef RO_AUTOSCAN_EN
      scan_q <= 1'b0;
`endif
    end else begin
      init_q <= 1'b1;

      if (accept) begin
        trim_q <= cmd_trim;
        gate_q <= cmd_gate;
`ifdef RO_AUTOSCAN_EN
        scan_q <= scan_en;
        sel_q  <= scan_en ? '0 : cmd_sel;
`else
        sel_q  <= cmd_sel;
`endif
      end else if (state_q == ST_RESULT && state_d == ST_SETUP) begin
        sel_q <= sel_q + SEL_W'(1);
      end

      if (state_d == ST_SETUP && state_q != ST_SETUP)
        tmr_q <= TMR_W'(SETTLE - 1);
      else if (state_d == ST_ENABLE && state_q != ST_ENABLE)
        tmr_q <= TMR_W'(WARM - 1);
      else if (tmr_q != '0)
        tmr_q <= tmr_q - TMR_W'(1);

      if (state_d == ST_GATE && state_q != ST_GATE)
        gcnt_q <= gate_q;
      else if (state_q == ST_GATE)
        gcnt_q <= gcnt_q - GATE_W'(1);

      // Each measurement starts from zero; saturation is sticky until then.
      if (state_d == ST_SETUP && state_q != ST_SETUP) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (state_q == ST_GATE && rise) begin
        if (cnt_q == {CNT_W{1'b1}}) ovf_q <= 1'b1;
        else                        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
